// File: rtl/led_chaser_game_n_if.sv
// ---------------------------------------------------------------------------
// led_chaser_game_n_if
// Player-side control bundle for the LED chaser core. The debounced button
// front-end drives it (master) and the game core consumes it (slave).
//   start_game   : level, begins/restarts a game from IDLE or GAME_OVER
//   button       : LED index the player is aiming at
//   button_valid : one-cycle strobe qualifying button
//   mode         : 0 = wrap, 1 = bounce; only looked at when a game starts
// ---------------------------------------------------------------------------
interface led_chaser_game_n_if #(
   parameter int BTN_W = 3
);
   logic             start_game;
   logic [BTN_W-1:0] button;
   logic             button_valid;
   logic             mode;

   modport master (output start_game, button, button_valid, mode);
   modport slave  (input  start_game, button, button_valid, mode);
endinterface

// File: rtl/led_chaser_game_n.sv
// ---------------------------------------------------------------------------
// led_chaser_game_n
// LED chaser game core. One lit LED steps across NUM_LEDS positions (wrap or
// bounce). A press on the matching index scores a hit and speeds the game up;
// a wrong press or TIMEOUT_STEPS steps without a press costs a life. After a
// hit/miss a flash phase is shown, then play restarts from position 0.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_ctl          : player control bundle (start_game, button, valid, mode)
//   o_led          : LED drive (registered)
//   o_score        : saturating hit count
//   o_lives        : remaining lives
//   o_hit, o_miss  : one-cycle pulses on catch / miss
//   o_game_over    : high while in GAME_OVER
// ---------------------------------------------------------------------------
module led_chaser_game_n #(
   parameter  int NUM_LEDS      = 8,
   parameter  int BTN_W         = $clog2(NUM_LEDS),
   parameter  int INIT_PERIOD   = 16,
   parameter  int MIN_PERIOD    = 4,
   parameter  int PERIOD_STEP   = 2,
   parameter  int TIMEOUT_STEPS = 2*NUM_LEDS,
   parameter  int FLASH_CYCLES  = 8,
   parameter  int MAX_LIVES     = 3,
   parameter  int SCORE_W       = 8,
   localparam int LIVES_W       = $clog2(MAX_LIVES+1)
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   led_chaser_game_n_if.slave   i_ctl,
   output logic [NUM_LEDS-1:0]  o_led,
   output logic [SCORE_W-1:0]   o_score,
   output logic [LIVES_W-1:0]   o_lives,
   output logic                 o_hit,
   output logic                 o_miss,
   output logic                 o_game_over
);
   localparam int PW = $clog2(INIT_PERIOD+1);
   localparam int TW = $clog2(TIMEOUT_STEPS+1);
   localparam int FW = $clog2(FLASH_CYCLES+1);

   localparam logic [NUM_LEDS-1:0] LED_ONE    = NUM_LEDS'(1);
   localparam logic [BTN_W-1:0]    POS_LAST   = BTN_W'(NUM_LEDS-1);
   localparam logic [PW-1:0]       P_INIT     = PW'(INIT_PERIOD);
   localparam logic [PW-1:0]       P_MIN      = PW'(MIN_PERIOD);
   localparam logic [TW-1:0]       TO_MAX     = TW'(TIMEOUT_STEPS);
   localparam logic [FW-1:0]       FL_LAST    = FW'(FLASH_CYCLES-1);
   localparam logic [LIVES_W-1:0]  LIVES_INIT = LIVES_W'(MAX_LIVES);

   typedef enum logic [2:0] {
      S_IDLE, S_PLAY, S_HIT_FLASH, S_MISS_FLASH, S_GAME_OVER
   } state_t;

   state_t              r_state;
   logic [NUM_LEDS-1:0] r_led;
   logic [SCORE_W-1:0]  r_score;
   logic [LIVES_W-1:0]  r_lives;
   logic                r_hit, r_miss, r_game_over;
   logic                r_mode;
   logic [BTN_W-1:0]    r_pos;
   logic                r_dir;          // 0 = up, 1 = down
   logic [PW-1:0]       r_period;
   logic [PW-1:0]       r_step_cnt;
   logic [TW-1:0]       r_to_cnt;
   logic [FW-1:0]       r_flash_cnt;

   logic [BTN_W-1:0]    w_pos_adv;
   logic                w_dir_adv;
   logic                w_press_hit;
   logic                w_step_end;

   // Next position/direction if the LED steps this cycle. In bounce mode the
   // direction flips while leaving an end, so the end position is shown once.
   always_comb begin
      w_pos_adv = r_pos;
      w_dir_adv = r_dir;
      if (!r_mode) begin
         w_pos_adv = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
      end else if (!r_dir) begin
         if (r_pos == POS_LAST) begin
            w_pos_adv = r_pos - 1'b1;
            w_dir_adv = 1'b1;
         end else begin
            w_pos_adv = r_pos + 1'b1;
         end
      end else begin
         if (r_pos == '0) begin
            w_pos_adv = r_pos + 1'b1;
            w_dir_adv = 1'b0;
         end else begin
            w_pos_adv = r_pos - 1'b1;
         end
      end
   end

   // Press is judged against the registered pos, before any same-edge step.
   // Out-of-range button values can never equal pos, so they miss naturally.
   assign w_press_hit = i_ctl.button_valid && (i_ctl.button == r_pos);
   assign w_step_end  = (r_step_cnt == r_period - PW'(1));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_led       <= '0;
         r_score     <= '0;
         r_lives     <= LIVES_INIT;
         r_hit       <= 1'b0;
         r_miss      <= 1'b0;
         r_game_over <= 1'b0;
         r_mode      <= 1'b0;
         r_pos       <= '0;
         r_dir       <= 1'b0;
         r_period    <= P_INIT;
         r_step_cnt  <= '0;
         r_to_cnt    <= '0;
         r_flash_cnt <= '0;
      end else begin
         r_hit  <= 1'b0;
         r_miss <= 1'b0;
         case (r_state)
            // Holding state: IDLE shows dark, GAME_OVER keeps all-on and the
            // final score/lives until a new game is requested.
            S_IDLE, S_GAME_OVER: begin
               if (i_ctl.start_game) begin
                  r_state     <= S_PLAY;
                  r_mode      <= i_ctl.mode;
                  r_score     <= '0;
                  r_lives     <= LIVES_INIT;
                  r_period    <= P_INIT;
                  r_pos       <= '0;
                  r_dir       <= 1'b0;
                  r_step_cnt  <= '0;
                  r_to_cnt    <= '0;
                  r_led       <= LED_ONE;
                  r_game_over <= 1'b0;
               end
            end
            S_PLAY: begin
               // A press wins over a same-edge timeout; with no press this
               // branch is the timeout miss.
               if (i_ctl.button_valid || (r_to_cnt == TO_MAX)) begin
                  r_flash_cnt <= '0;
                  r_to_cnt    <= '0;
                  r_led       <= '1;
                  if (w_press_hit) begin
                     r_hit   <= 1'b1;
                     r_state <= S_HIT_FLASH;
                     if (r_score != '1) r_score <= r_score + 1'b1;
                     if (int'(r_period) >= MIN_PERIOD + PERIOD_STEP)
                        r_period <= r_period - PW'(PERIOD_STEP);
                     else
                        r_period <= P_MIN;
                  end else begin
                     r_miss  <= 1'b1;
                     r_state <= S_MISS_FLASH;
                     if (r_lives != '0) r_lives <= r_lives - 1'b1;
                  end
               end else if (w_step_end) begin
                  r_step_cnt <= '0;
                  r_pos      <= w_pos_adv;
                  r_dir      <= w_dir_adv;
                  r_to_cnt   <= r_to_cnt + 1'b1;
                  r_led      <= LED_ONE << w_pos_adv;
               end else begin
                  r_step_cnt <= r_step_cnt + 1'b1;
               end
            end
            S_HIT_FLASH, S_MISS_FLASH: begin
               if (r_flash_cnt == FL_LAST) begin
                  if ((r_state == S_MISS_FLASH) && (r_lives == '0)) begin
                     r_state     <= S_GAME_OVER;
                     r_game_over <= 1'b1;
                     r_led       <= '1;
                  end else begin
                     r_state    <= S_PLAY;
                     r_pos      <= '0;
                     r_dir      <= 1'b0;
                     r_step_cnt <= '0;
                     r_to_cnt   <= '0;
                     r_led      <= LED_ONE;
                  end
               end else begin
                  r_flash_cnt <= r_flash_cnt + 1'b1;
                  // Miss flash blinks; it entered with all LEDs on.
                  if (r_state == S_MISS_FLASH) r_led <= ~r_led;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_led       = r_led;
   assign o_score     = r_score;
   assign o_lives     = r_lives;
   assign o_hit       = r_hit;
   assign o_miss      = r_miss;
   assign o_game_over = r_game_over;
endmodule

// File: tb/tb_led_chaser_game_n.sv
module tb_led_chaser_game_n;
  localparam int N = 4, BW = 2, IP = 4, MP = 2, PS = 1, TO = 8, FL = 3, ML = 2, SW = 8;

  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] led;
  logic [SW-1:0] score;
  logic [1:0] lives;
  logic hit, miss, game_over;

  led_chaser_game_n_if #(.BTN_W(BW)) ctl();

  led_chaser_game_n #(
    .NUM_LEDS(N), .BTN_W(BW), .INIT_PERIOD(IP), .MIN_PERIOD(MP), .PERIOD_STEP(PS),
    .TIMEOUT_STEPS(TO), .FLASH_CYCLES(FL), .MAX_LIVES(ML), .SCORE_W(SW)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_ctl(ctl), .o_led(led), .o_score(score),
    .o_lives(lives), .o_hit(hit), .o_miss(miss), .o_game_over(game_over)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: game phase plus elapsed play cycles; LED position is
  // derived arithmetically from how many whole periods have elapsed.
  // phase: 0 idle, 1 play, 2 hit flash, 3 miss flash, 4 game over
  int m_ph = 0, m_mode = 0, m_period = IP, m_score = 0, m_lives = ML;
  int m_tick = 0, m_fl = 0, m_hit = 0, m_miss = 0;

  function automatic int tour(int s, int md);
    int k;
    if (md == 0) return s % N;
    k = s % (2*N-2);
    return (k < N) ? k : 2*N-2-k;
  endfunction

  function automatic int m_pos();
    return tour(m_tick / m_period, m_mode);
  endfunction

  function automatic logic [N-1:0] m_led();
    case (m_ph)
      0: return '0;
      1: return N'(1) << m_pos();
      3: return (m_fl % 2 == 0) ? {N{1'b1}} : {N{1'b0}};
      default: return {N{1'b1}};
    endcase
  endfunction

  task automatic model_edge(input bit rst, input bit st, input bit bv, input int btn, input bit md);
    m_hit = 0; m_miss = 0;
    if (rst) begin
      m_ph = 0; m_mode = 0; m_score = 0; m_lives = ML; m_period = IP; m_tick = 0; m_fl = 0;
      return;
    end
    case (m_ph)
      0, 4: if (st) begin
        m_ph = 1; m_mode = int'(md); m_score = 0; m_lives = ML; m_period = IP; m_tick = 0;
      end
      1: begin
        if (bv && btn == m_pos()) begin
          m_hit = 1; m_ph = 2; m_fl = 0;
          if (m_score < (1 << SW) - 1) m_score++;
          m_period = (m_period - PS < MP) ? MP : m_period - PS;
        end else if (bv || (m_tick / m_period) >= TO) begin
          m_miss = 1; m_ph = 3; m_fl = 0;
          if (m_lives > 0) m_lives--;
        end else m_tick++;
      end
      default: begin
        if (m_fl == FL-1) begin
          m_ph = (m_ph == 3 && m_lives == 0) ? 4 : 1;
          m_tick = 0;
        end else m_fl++;
      end
    endcase
  endtask

  // One clock: drive inputs, advance DUT and model together, settle past the edge.
  task automatic step(input bit rst, input bit st, input bit bv, input int btn, input bit md);
    reset = rst; ctl.start_game = st; ctl.button_valid = bv; ctl.button = btn[BW-1:0]; ctl.mode = md;
    @(posedge clk);
    model_edge(rst, st, bv, btn, md);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic wait_led(input logic [N-1:0] tgt, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (led === tgt) begin ok = 1'b1; return; end
      idle();
    end
    ok = (led === tgt);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    checks++; if (led !== 4'b0000) begin errors++; $display("FAIL reset_led: got %b want 0000", led); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
    checks++; if (lives !== 2'd2) begin errors++; $display("FAIL reset_lives: got %0d want 2", lives); end
    checks++; if ({hit, miss, game_over} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {hit, miss, game_over}); end
    idle(); idle();
    checks++; if (led !== 4'b0000) begin errors++; $display("FAIL idle_led: got %b want 0000", led); end
  endtask

  task automatic test_wrap();
    logic [N-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    checks++; if (score !== 8'd0 || lives !== 2'd2) begin errors++; $display("FAIL wrap_start: got score %0d lives %0d want 0 2", score, lives); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (led !== seq[k]) begin errors++; $display("FAIL wrap_seq[%0d]: got %b want %b", k, led, seq[k]); end
      for (int c = 0; c < IP; c++) idle();
    end
  endtask

  task automatic test_bounce();
    logic [N-1:0] seq [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      checks++; if (led !== seq[k]) begin errors++; $display("FAIL bounce_seq[%0d]: got %b want %b", k, led, seq[k]); end
      for (int c = 0; c < IP; c++) idle();
    end
  endtask

  task automatic test_hit_period();
    bit ok; int n;
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    wait_led(4'b0100, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hit_wait: led %b never reached 0100", led); end
    step(1'b0, 1'b0, 1'b1, 2, 1'b0);
    checks++; if (hit !== 1'b1 || miss !== 1'b0) begin errors++; $display("FAIL hit_pulse: got hit %b miss %b want 1 0", hit, miss); end
    checks++; if (score !== 8'd1) begin errors++; $display("FAIL hit_score: got %0d want 1", score); end
    for (int c = 0; c < FL; c++) begin
      checks++; if (led !== 4'b1111) begin errors++; $display("FAIL hit_flash[%0d]: got %b want 1111", c, led); end
      idle();
      if (c == 0) begin checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_one_cycle: got %b want 0", hit); end end
    end
    checks++; if (led !== 4'b0001) begin errors++; $display("FAIL hit_restart: got %b want 0001", led); end
    n = 0;
    for (int i = 0; i < 20; i++) begin idle(); n++; if (led !== 4'b0001) break; end
    checks++; if (n != 3) begin errors++; $display("FAIL hit_period3: got %0d want 3", n); end
    for (int h = 0; h < 3; h++) begin
      step(1'b0, 1'b0, 1'b1, m_pos(), 1'b0);
      checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_more[%0d]: got %b want 1", h, hit); end
      for (int c = 0; c < FL; c++) idle();
    end
    checks++; if (score !== 8'd4) begin errors++; $display("FAIL hit_score4: got %0d want 4", score); end
    n = 0;
    for (int i = 0; i < 20; i++) begin idle(); n++; if (led !== 4'b0001) break; end
    checks++; if (n != MP) begin errors++; $display("FAIL hit_period_floor: got %0d want %0d", n, MP); end
  endtask

  task automatic test_miss_timeout();
    bit ok; int n;
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    wait_led(4'b1000, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL miss_wait: led %b never reached 1000", led); end
    step(1'b0, 1'b0, 1'b1, 1, 1'b0);
    checks++; if (miss !== 1'b1 || hit !== 1'b0) begin errors++; $display("FAIL miss_pulse: got miss %b hit %b want 1 0", miss, hit); end
    checks++; if (lives !== 2'd1) begin errors++; $display("FAIL miss_lives: got %0d want 1", lives); end
    checks++; if (led !== 4'b1111) begin errors++; $display("FAIL miss_flash0: got %b want 1111", led); end
    idle();
    checks++; if (led !== 4'b0000 || miss !== 1'b0) begin errors++; $display("FAIL miss_flash1: got led %b miss %b want 0000 0", led, miss); end
    idle();
    checks++; if (led !== 4'b1111) begin errors++; $display("FAIL miss_flash2: got %b want 1111", led); end
    idle();
    checks++; if (led !== 4'b0001 || game_over !== 1'b0) begin errors++; $display("FAIL miss_restart: got led %b go %b want 0001 0", led, game_over); end
    n = 0;
    for (int i = 0; i < 60; i++) begin idle(); n++; if (miss === 1'b1) break; end
    checks++; if (miss !== 1'b1 || n != TO*IP+1) begin errors++; $display("FAIL timeout_miss: got miss %b after %0d cycles want 1 after %0d", miss, n, TO*IP+1); end
    checks++; if (lives !== 2'd0) begin errors++; $display("FAIL timeout_lives: got %0d want 0", lives); end
    for (int c = 0; c < FL; c++) idle();
    checks++; if (game_over !== 1'b1 || led !== 4'b1111) begin errors++; $display("FAIL game_over: got go %b led %b want 1 1111", game_over, led); end
    idle(); idle();
    checks++; if (game_over !== 1'b1 || lives !== 2'd0 || score !== 8'd0) begin errors++; $display("FAIL game_over_hold: got go %b lives %0d score %0d want 1 0 0", game_over, lives, score); end
  endtask

  task automatic test_game_over_restart();
    int n;
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    checks++; if (game_over !== 1'b0 || score !== 8'd0 || lives !== 2'd2 || led !== 4'b0001) begin
      errors++; $display("FAIL restart: got go %b score %0d lives %0d led %b want 0 0 2 0001", game_over, score, lives, led); end
    n = 0;
    for (int i = 0; i < 20; i++) begin idle(); n++; if (led !== 4'b0001) break; end
    checks++; if (n != IP) begin errors++; $display("FAIL restart_period: got %0d want %0d", n, IP); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(); idle();
    step(1'b0, 1'b0, 1'b1, m_pos(), 1'b0);
    for (int c = 0; c < FL + 2; c++) idle();
    checks++; if (score !== 8'd1) begin errors++; $display("FAIL mid_score_before: got %0d want 1", score); end
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    checks++; if (led !== 4'b0000 || score !== 8'd0 || lives !== 2'd2 || game_over !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got led %b score %0d lives %0d go %b want 0000 0 2 0", led, score, lives, game_over); end
    for (int c = 0; c < 6; c++) idle();
    checks++; if (led !== 4'b0000) begin errors++; $display("FAIL mid_reset_idle: got %b want 0000", led); end
  endtask

  task automatic test_step_edge();
    bit ok;
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    wait_led(4'b0010, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL edge_wait: led %b never reached 0010", led); end
    for (int c = 0; c < IP - 1; c++) idle();
    step(1'b0, 1'b0, 1'b1, 1, 1'b0);
    checks++; if (hit !== 1'b1 || miss !== 1'b0) begin errors++; $display("FAIL edge_hit: got hit %b miss %b want 1 0", hit, miss); end
    step(1'b0, 1'b0, 1'b1, 3, 1'b0);
    checks++; if (hit !== 1'b0 || miss !== 1'b0 || lives !== 2'd2 || led !== 4'b1111) begin
      errors++; $display("FAIL flash_press_ignored: got hit %b miss %b lives %0d led %b want 0 0 2 1111", hit, miss, lives, led); end
    idle(); idle();
    checks++; if (led !== 4'b0001 || score !== 8'd1) begin errors++; $display("FAIL edge_after_flash: got led %b score %0d want 0001 1", led, score); end
  endtask

  task automatic test_random();
    bit rst, st, bv, md; int btn;
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 7) == 0);
      bv  = ($urandom_range(0, 5) == 0);
      md  = 1'($urandom_range(0, 1));
      btn = int'($urandom_range(0, N-1));
      step(rst, st, bv, btn, md);
      checks++;
      if (led !== m_led() || score !== SW'(m_score) || lives !== 2'(m_lives) || hit !== 1'(m_hit) ||
          miss !== 1'(m_miss) || game_over !== (m_ph == 4)) begin
        errors++;
        $display("FAIL random[%0d]: got led %b score %0d lives %0d hit %b miss %b go %b want %b %0d %0d %0d %0d %0d",
                 i, led, score, lives, hit, miss, game_over, m_led(), m_score, m_lives, m_hit, m_miss, int'(m_ph == 4));
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wrap();
    test_bounce();
    test_hit_period();
    test_miss_timeout();
    test_game_over_restart();
    test_reset_mid();
    test_step_edge();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_chaser_game_n.md
Name: led_chaser_game_n

Overview:
Parametrised next-generation LED chaser game core. A single lit LED steps across NUM_LEDS positions in either wrap or bounce mode. The player catches it by presenting the matching button index with a valid strobe. Hits raise the score and shorten the step period; misses and timeouts cost lives until game over. The block sits between the debounced button front-end and the board LED/score display drivers.

Parameters:
NUM_LEDS, 8, number of LED positions (>=2)
BTN_W, $clog2(NUM_LEDS), width of the button index
INIT_PERIOD, 16, clock cycles per LED step at game start (>=2)
MIN_PERIOD, 4, floor for the step period (>=1, <=INIT_PERIOD)
PERIOD_STEP, 2, period decrement applied per hit
TIMEOUT_STEPS, 2*NUM_LEDS, LED steps without a press before an automatic miss
FLASH_CYCLES, 8, duration of the hit/miss indication phase
MAX_LIVES, 3, lives at game start (>=1)
SCORE_W, 8, score width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_game  in  1  level; sampled each cycle
button  in  BTN_W  player-selected LED index
button_valid  in  1  one-cycle press strobe qualifying button
mode  in  1  0 = wrap, 1 = bounce; sampled only on game start
led  out  NUM_LEDS  LED drive, registered
score  out  SCORE_W  hit count, registered
lives  out  $clog2(MAX_LIVES+1)  remaining lives
hit  out  1  one-cycle pulse on a successful catch
miss  out  1  one-cycle pulse on wrong press or timeout
game_over  out  1  high in GAME_OVER state

Behaviour:
- Single clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, led=0, score=0, lives=MAX_LIVES, hit=0, miss=0, game_over=0, pos=0, dir=up, period=INIT_PERIOD, step counter=0, timeout counter=0.
- A reset asserted mid-game forces the reset values on the next edge, whatever the current state.
- States: IDLE, PLAY, HIT_FLASH, MISS_FLASH, GAME_OVER.
- IDLE:
  - led=0.
  - start_game=1 -> PLAY. Score, lives and period reload; pos=0, dir=up; mode is latched.
- PLAY:
  - led is one-hot at pos.
  - The step counter counts 0..period-1. At period-1 it wraps to 0, pos advances, and the timeout counter increments.
  - Wrap mode: pos goes NUM_LEDS-1 -> 0.
  - Bounce mode: dir flips at pos=NUM_LEDS-1 and at pos=0, so no end position is repeated. Sequence for N=4 is 0,1,2,3,2,1,0,1...
- Press in PLAY (button_valid=1):
  - The press is compared against the current registered pos, i.e. the value before any advance on that same edge.
  - button==pos -> hit. hit=1 for one cycle, score+1 (saturates at all-ones), period=max(period-PERIOD_STEP, MIN_PERIOD) with no underflow, -> HIT_FLASH.
  - button!=pos, including any button>=NUM_LEDS -> miss. miss=1 for one cycle, lives-1, -> MISS_FLASH.
  - Any press clears the timeout counter.
- Timeout: when the timeout counter reaches TIMEOUT_STEPS, a miss is taken exactly as for a wrong press.
- Simultaneous press and timeout on the same edge: the press takes priority.
- Pulse timing: hit/miss and score/lives all update on the edge that samples the press. Latency is 1 cycle to outputs.
- HIT_FLASH: led=all ones for FLASH_CYCLES cycles, then -> PLAY with pos=0, dir=up, both counters=0.
- MISS_FLASH: led alternates all-ones/all-zero each cycle for FLASH_CYCLES cycles, then either:
  - lives==0 -> GAME_OVER;
  - otherwise -> PLAY with the same restart values as after a hit.
- Presses during HIT_FLASH or MISS_FLASH are ignored, with no pulses.
- GAME_OVER:
  - game_over=1, led=all ones; score and lives are held.
  - start_game=1 -> PLAY with a full reload (as from IDLE); game_over clears on that edge.
- start_game is ignored in PLAY and in both flash states.
- mode changes outside game start have no effect.

Test Plan:
(Bench parameters: NUM_LEDS=4, INIT_PERIOD=4, MIN_PERIOD=2, PERIOD_STEP=1, TIMEOUT_STEPS=8, FLASH_CYCLES=3, MAX_LIVES=2.)
1. Reset, start_game pulse, mode=0 -> led steps 0001,0010,0100,1000,0001 every 4 cycles; score=0, lives=2.
2. Start with mode=1 -> led sequence 0001,0010,0100,1000,0100,0010,0001; no repeated end value.
3. Press button=2 while led=0100 -> hit pulse 1 cycle, score=1, led=1111 for 3 cycles, restart at 0001, step period now 3. Three further hits -> period reaches 2 and holds.
4. Press button=1 while led=1000 -> miss pulse, lives=1, led toggles for 3 cycles. Then no presses for 8 steps -> timeout miss, lives=0, game_over=1, led=1111.
5. In GAME_OVER, assert start_game -> game_over=0, score=0, lives=2, period=4. Assert reset mid-PLAY -> next cycle led=0, state IDLE, score=0.
6. Press coinciding with the step edge (counter=3, pos=1, button=1) -> hit. Press with button=3 during HIT_FLASH -> ignored, no miss.
